// File: rtl/io_responder.sv
// rtl/io_responder.sv - IO-bus responder: LED register, UART TX FIFO + 8N1 serializer, cycle counter.
// Read data is combinational from the address; all state changes on the write edge.
module io_responder #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int LED_BITS   = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [31:0]         IO_memAddr_i,
    output logic [31:0]         IO_memRData_o,
    input  logic [31:0]         IO_memWData_i,
    input  logic                IO_memWr_i,
    output logic [LED_BITS-1:0] leds_o,
    output logic                uart_tx_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic [LED_BITS-1:0] leds_q, leds_d;
    logic [31:0]         cycle_q, cycle_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [7:0]          mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]    count_q, count_d;

    logic [2:0] reg_sel;
    logic       wr_leds, wr_data, wr_status, wr_cycle;
    logic       fifo_full, fifo_empty, push, pop, busy;
    logic       unused_addr;

    assign reg_sel     = IO_memAddr_i[4:2];
    assign unused_addr = ^{IO_memAddr_i[31:5], IO_memAddr_i[1:0]};

    assign wr_leds    = IO_memWr_i && (reg_sel == 3'd0);
    assign wr_data    = IO_memWr_i && (reg_sel == 3'd1);
    assign wr_status  = IO_memWr_i && (reg_sel == 3'd2);
    assign wr_cycle   = IO_memWr_i && (reg_sel == 3'd3);

    assign fifo_full  = (count_q == OCC_FULL);
    assign fifo_empty = (count_q == '0);
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push       = wr_data && (!fifo_full || pop);
    assign busy       = !fifo_empty || (state_q != S_IDLE);

    always_comb begin
        leds_d   = leds_q;
        cycle_d  = cycle_q + 32'd1;
        ovf_d    = ovf_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_leds) leds_d = IO_memWData_i[LED_BITS-1:0];
        if (wr_cycle) cycle_d = IO_memWData_i;
        if (wr_status && IO_memWData_i[2]) ovf_d = 1'b0;
        if (wr_data && !push) ovf_d = 1'b1;

        if (push) begin
            mem_d[wr_ptr_q] = IO_memWData_i[7:0];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + DIV_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (pop) begin
                    state_d = S_START;
                    shift_d = mem_q[rd_ptr_q];
                end
            end
            S_START: begin
                if (bit_cnt_q == DIV_LAST) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_cnt_q == DIV_LAST) begin
                    bit_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (bit_cnt_q == DIV_LAST) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is decoded from the next state so the pin flop lines up with the state.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            leds_q    <= '0;
            cycle_q   <= '0;
            ovf_q     <= 1'b0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            leds_q    <= leds_d;
            cycle_q   <= cycle_d;
            ovf_q     <= ovf_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        IO_memRData_o = '0;
        case (reg_sel)
            3'd0:    IO_memRData_o = 32'(leds_q);
            3'd2:    IO_memRData_o = {16'd0, 8'(count_q), 5'd0, ovf_q, busy, fifo_full};
            3'd3:    IO_memRData_o = cycle_q;
            default: IO_memRData_o = '0;
        endcase
    end

    assign leds_o    = leds_q;
    assign uart_tx_o = tx_q;

endmodule

// File: tb/tb_io_responder.sv
// tb/tb_io_responder.sv - directed self-checking bench for io_responder (CLK_DIV=4, FIFO_DEPTH=8).
module tb_io_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic        wr;
    logic [7:0]  leds;
    logic        tx;

    int tests  = 0;
    int failed = 0;

    io_responder #(.CLK_DIV(4), .FIFO_DEPTH(8), .LED_BITS(8)) dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .IO_memAddr_i  (addr),
        .IO_memRData_o (rdata),
        .IO_memWData_i (wdata),
        .IO_memWr_i    (wr),
        .leds_o        (leds),
        .uart_tx_o     (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Line receiver: samples mid-bit on falling clock edges, discards frames cut by reset.
    logic [8:0] rx_q[$];
    int         rx_cnt  = 0;
    logic       rx_busy = 1'b0;
    logic [7:0] rx_sh;

    always @(negedge clk) begin
        if (rst) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx == 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_sh = {tx, rx_sh[7:1]};
            if (rx_cnt == 38) begin
                rx_q.push_back({tx, rx_sh});
                rx_busy = 1'b0;
            end
        end
    end

    logic [31:0] d;
    logic [7:0]  exp_byte;
    logic        exp_tx;

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; wr = 1'b0;
        #3;
        check("por_leds", 32'(leds), 32'h0);
        check("por_tx", 32'(tx), 32'h1);
        bus_rd(32'h08, d);
        check("por_status", d, 32'h0);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        bus_wr(32'h00, 32'h1234_5AC3);
        check("led_pins", 32'(leds), 32'hC3);
        bus_rd(32'h00, d);
        check("led_read", d, 32'h0000_00C3);
        bus_rd(32'h14, d);
        check("unmapped_read", d, 32'h0);

        #2 rst = 1'b1;
        #1;
        check("async_rst_leds", 32'(leds), 32'h0);
        check("async_rst_tx", 32'(tx), 32'h1);
        bus_rd(32'h08, d);
        check("async_rst_status", d, 32'h0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_rd(32'h0C, d);
            check($sformatf("cycle_after_rst_%0d", i), d, 32'(i));
            next_cycle();
        end

        rx_q.delete();
        bus_wr(32'h04, 32'h0000_00A5);
        bus_rd(32'h08, d);
        check("status_one_queued", d, 32'h0000_0102);
        for (int c = 1; c <= 42; c++) begin
            if (c < 2 || c > 37) exp_tx = 1'b1;
            else if (c < 6) exp_tx = 1'b0;
            else begin
                exp_byte = 8'hA5 >> ((c - 6) / 4);
                exp_tx   = exp_byte[0];
            end
            check($sformatf("frame_tx_c%0d", c), 32'(tx), 32'(exp_tx));
            bus_rd(32'h08, d);
            check($sformatf("frame_busy_c%0d", c), 32'(d[1]), (c <= 41) ? 32'h1 : 32'h0);
            next_cycle();
        end
        check("frame_rx_count", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("frame_rx_byte", 32'(rx_q[0]), 32'h1A5);

        bus_wr(32'h0C, 32'hFFFF_FFFE);
        bus_rd(32'h0C, d);
        check("cycle_load", d, 32'hFFFF_FFFE);
        next_cycle();
        bus_rd(32'h0C, d);
        check("cycle_max", d, 32'hFFFF_FFFF);
        next_cycle();
        bus_rd(32'h0C, d);
        check("cycle_wrap", d, 32'h0);

        rx_q.delete();
        for (int i = 0; i < 10; i++) bus_wr(32'h04, 32'h10 + 32'(i));
        bus_rd(32'h08, d);
        check("ovf_status", d, 32'h0000_0807);
        bus_wr(32'h08, 32'h0);
        bus_rd(32'h08, d);
        check("ovf_keep_on_zero", d, 32'h0000_0807);
        bus_wr(32'h08, 32'h4);
        bus_rd(32'h08, d);
        check("ovf_clear", d, 32'h0000_0803);
        for (int n = 0; n < 2000; n++) begin
            bus_rd(32'h08, d);
            if (!d[1]) break;
            next_cycle();
        end
        check("drain_busy", 32'(d[1]), 32'h0);
        check("drain_rx_count", rx_q.size(), 32'd9);
        for (int i = 0; i < 9 && i < rx_q.size(); i++)
            check($sformatf("drain_rx_%0d", i), 32'(rx_q[i]), 32'h100 | (32'h10 + 32'(i)));

        rx_q.delete();
        bus_wr(32'h04, 32'h00);
        bus_wr(32'h04, 32'h11);
        bus_wr(32'h04, 32'h22);
        bus_wr(32'h04, 32'h33);
        bus_rd(32'h08, d);
        check("midrst_queued", d, 32'h0000_0302);
        repeat (8) next_cycle();
        check("midrst_tx_low", 32'(tx), 32'h0);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_high", 32'(tx), 32'h1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        bus_rd(32'h08, d);
        check("midrst_status", d, 32'h0);
        repeat (100) next_cycle();
        check("midrst_no_frames", rx_q.size(), 32'd0);
        check("midrst_idle_tx", 32'(tx), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
